alu_result_buffer: RTL and testbench



---
 rtl/alu_result_buffer.sv | 161 ++++++++++++++++
 tb/tb_alu_result_buffer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_buffer.sv
// -----------------------------------------------------------------------------
// alu_result_buffer
//
// Registered in-order result queue placed directly after the 32-bit
// adder/subtracter. Each accepted entry stores the result, carry-out, signed
// overflow and a zero flag derived at capture time. Entries leave through a
// show-ahead valid/ready port. A sticky overflow indicator and a wrapping
// count of accepted results are kept alongside.
//
// Ports
//   clk             rising-edge clock
//   reset_n         asynchronous active-low reset
//   in_valid        producer presents a settled result
//   in_ready        buffer can take an entry this cycle (not full)
//   in_result       ALU sum/difference
//   in_carryout     ALU carry-out
//   in_overflow     ALU signed overflow
//   out_valid       head entry present on out_* (not empty)
//   out_ready       consumer takes the head entry this cycle
//   out_result      head entry result
//   out_carryout    head entry carry-out
//   out_overflow    head entry overflow
//   out_zero        head entry result was zero
//   count           occupancy, 0..DEPTH
//   sticky_overflow an overflowing entry was accepted since the last clear
//   sticky_clear    clears sticky_overflow (a same-cycle set wins)
//   accepted        number of accepted entries, modulo 2^CNTW
// -----------------------------------------------------------------------------
module alu_result_buffer #(
  parameter int DEPTH = 4,   // power of two, >= 2
  parameter int CNTW  = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_result,
  input  logic                     in_carryout,
  input  logic                     in_overflow,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_result,
  output logic                     out_carryout,
  output logic                     out_overflow,
  output logic                     out_zero,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     sticky_overflow,
  input  logic                     sticky_clear,
  output logic [CNTW-1:0]          accepted
);

  localparam int PTRW = $clog2(DEPTH);
  localparam int CW   = PTRW + 1;

  typedef struct packed {
    logic [31:0] result;
    logic        carryout;
    logic        overflow;
    logic        zero;
  } entry_t;

  entry_t            mem_q [DEPTH];
  logic [PTRW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              sticky_q, sticky_d;
  logic [CNTW-1:0]   accepted_q, accepted_d;

  logic   push, pop;
  entry_t push_entry;
  entry_t head_entry;

  // Handshake flags depend only on registered occupancy, so there is no
  // combinational path from in_valid/out_ready to in_ready/out_valid.
  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);

  assign push = in_valid  && in_ready;
  assign pop  = out_valid && out_ready;

  // Zero flag is derived once, at capture, and stored with the entry.
  assign push_entry.result   = in_result;
  assign push_entry.carryout = in_carryout;
  assign push_entry.overflow = in_overflow;
  assign push_entry.zero     = (in_result == 32'h0);

  // Show-ahead: the slot at rd_ptr is always driven, even when empty.
  assign head_entry   = mem_q[rd_ptr_q];
  assign out_result   = head_entry.result;
  assign out_carryout = head_entry.carryout;
  assign out_overflow = head_entry.overflow;
  assign out_zero     = head_entry.zero;

  assign count           = count_q;
  assign sticky_overflow = sticky_q;
  assign accepted        = accepted_q;

  // NOTE: every output of this block gets a default first so that no path
  // through the case/if statements leaves a signal unassigned (no latches).
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    sticky_d   = sticky_q;
    accepted_d = accepted_q;

    if (push) begin
      wr_ptr_d   = wr_ptr_q + PTRW'(1);   // DEPTH is a power of two: wraps naturally
      accepted_d = accepted_q + CNTW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTRW'(1);
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Clear first, then set, so a same-cycle overflow push wins.
    if (sticky_clear) begin
      sticky_d = 1'b0;
    end
    if (push && in_overflow) begin
      sticky_d = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      sticky_q   <= 1'b0;
      accepted_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      sticky_q   <= sticky_d;
      accepted_q <= accepted_d;
    end
  end

  // NOTE: the storage array is deliberately reset, because out_* expose the
  // slot at rd_ptr even when empty and must read as zero after reset. This
  // forces the array into flops rather than a RAM macro.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end

endmodule

// File: tb/tb_alu_result_buffer.sv
// -----------------------------------------------------------------------------
// tb_alu_result_buffer
//
// Directed scenarios followed by a randomized phase. Expected values come from
// a queue-based reference model: a queue of pending entries, a short history
// of the last DEPTH accepted entries (what the empty buffer shows), a sticky
// flag and an accepted counter.
// -----------------------------------------------------------------------------
module tb_alu_result_buffer;

  localparam int DEPTH = 4;
  localparam int CNTW  = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic        in_carryout;
  logic        in_overflow;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_carryout;
  logic        out_overflow;
  logic        out_zero;
  logic [2:0]  count;
  logic        sticky_overflow;
  logic        sticky_clear;
  logic [CNTW-1:0] accepted;

  always #5 clk = ~clk;

  alu_result_buffer #(.DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_result       (in_result),
    .in_carryout     (in_carryout),
    .in_overflow     (in_overflow),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_result      (out_result),
    .out_carryout    (out_carryout),
    .out_overflow    (out_overflow),
    .out_zero        (out_zero),
    .count           (count),
    .sticky_overflow (sticky_overflow),
    .sticky_clear    (sticky_clear),
    .accepted        (accepted)
  );

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [31:0] r;
    logic        c;
    logic        o;
    logic        z;
  } ent_t;

  ent_t q[$];      // entries waiting to be consumed, oldest first
  ent_t hist[$];   // last DEPTH accepted entries, oldest first
  logic m_sticky;
  int   m_acc;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    hist.delete();
    m_sticky = 1'b0;
    m_acc    = 0;
  endtask

  // Apply the rules to the inputs present at the rising edge.
  task automatic model_edge();
    bit   do_push, do_pop;
    ent_t e;
    do_push = in_valid && (q.size() != DEPTH);
    do_pop  = (q.size() != 0) && out_ready;
    if (do_pop) void'(q.pop_front());
    if (sticky_clear) m_sticky = 1'b0;
    if (do_push) begin
      e.r = in_result;
      e.c = in_carryout;
      e.o = in_overflow;
      e.z = (in_result == 32'h0);
      q.push_back(e);
      hist.push_back(e);
      if (hist.size() > DEPTH) void'(hist.pop_front());
      m_acc = (m_acc + 1) % (1 << CNTW);
      if (in_overflow) m_sticky = 1'b1;
    end
  endtask

  // When empty, the buffer shows the slot about to be written next, which
  // holds the oldest of the last DEPTH accepted entries (zero if fewer).
  task automatic check_all();
    ent_t exp_e;
    if (q.size() != 0)            exp_e = q[0];
    else if (hist.size() == DEPTH) exp_e = hist[0];
    else                           exp_e = '0;
    check("count",     count,           q.size());
    check("in_ready",  in_ready,        q.size() != DEPTH);
    check("out_valid", out_valid,       q.size() != 0);
    check("out_result", out_result,     exp_e.r);
    check("out_carry", out_carryout,    exp_e.c);
    check("out_ovf",   out_overflow,    exp_e.o);
    check("out_zero",  out_zero,        exp_e.z);
    check("sticky",    sticky_overflow, m_sticky);
    check("accepted",  accepted,        m_acc);
  endtask

  task automatic step();
    @(posedge clk);
    if (!reset_n) model_reset();
    else          model_edge();
    #1;
    check_all();
  endtask

  task automatic drive(input logic v, input logic [31:0] r, input logic c,
                       input logic o, input logic rdy, input logic clr);
    in_valid     = v;
    in_result    = r;
    in_carryout  = c;
    in_overflow  = o;
    out_ready    = rdy;
    sticky_clear = clr;
  endtask

  int acc_before;

  initial begin
    reset_n = 1'b0;
    drive(0, 32'h0, 0, 0, 0, 0);
    model_reset();

    // Reset then idle
    step();
    step();
    reset_n = 1'b1;
    step();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready",  in_ready,  1'b1);
    check("rst_count",     count,     3'd0);
    check("rst_result",    out_result, 32'h0);
    check("rst_zero",      out_zero,  1'b0);
    check("rst_accepted",  accepted,  16'd0);

    // Single push then pop
    drive(1, 32'h0000_0005, 0, 0, 0, 0);
    step();
    check("single_valid",  out_valid,  1'b1);
    check("single_result", out_result, 32'h5);
    check("single_zero",   out_zero,   1'b0);
    drive(0, 32'h0, 0, 0, 1, 0);
    step();
    check("single_empty",  count, 3'd0);

    // Fill, ignored 5th push, drain, then wrapped reuse
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 32'(i), 0, 0, 0, 0);
      step();
    end
    check("fill_count",    count,    3'd4);
    check("fill_in_ready", in_ready, 1'b0);
    check("fill_zero",     out_zero, 1'b1);
    acc_before = m_acc;
    drive(1, 32'd99, 1, 1, 0, 0);
    step();
    check("full_ignored",  accepted, 16'(acc_before));
    check("full_sticky",   sticky_overflow, 1'b0);
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < DEPTH; i++) begin
        check("drain_order", out_result, 32'(pass * 10 + i));
        drive(0, 32'h0, 0, 0, 1, 0);
        step();
      end
      check("drain_empty", out_valid, 1'b0);
      if (pass == 0) begin
        for (int i = 0; i < DEPTH; i++) begin
          drive(1, 32'(10 + i), i[0], 0, 0, 0);
          step();
        end
      end
    end

    // Simultaneous push/pop at count=2
    drive(1, 32'd100, 0, 0, 0, 0); step();
    drive(1, 32'd101, 0, 0, 0, 0); step();
    acc_before = m_acc;
    for (int i = 0; i < 10; i++) begin
      drive(1, 32'(200 + i), 1, 0, 1, 0);
      step();
      check("pp_count", count, 3'd2);
    end
    check("pp_accepted", accepted, 16'(acc_before + 10));
    check("pp_head", out_result, 32'd208);

    // Sticky overflow: set, set+clear, clear alone
    drive(1, 32'h8000_0000, 0, 1, 1, 0);
    step();
    check("sticky_set", sticky_overflow, 1'b1);
    drive(1, 32'h8000_0000, 0, 1, 1, 1);
    step();
    check("sticky_set_wins", sticky_overflow, 1'b1);
    drive(0, 32'h0, 0, 0, 1, 1);
    step();
    check("sticky_cleared", sticky_overflow, 1'b0);
    drive(0, 32'h0, 0, 0, 1, 0);
    for (int i = 0; i < DEPTH; i++) step();

    // Asynchronous reset with count=3
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'(300 + i), 1, 1, 0, 0);
      step();
    end
    check("pre_rst_count", count, 3'd3);
    drive(0, 32'h0, 0, 0, 0, 0);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_count", count,     3'd0);
    check("async_valid", out_valid, 1'b0);
    check("async_ready", in_ready,  1'b1);
    model_reset();
    step();
    reset_n = 1'b1;
    step();
    step();
    check("post_rst_valid",  out_valid,  1'b0);
    check("post_rst_result", out_result, 32'h0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 99) < 60,
            ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom,
            1'($urandom), 1'($urandom),
            $urandom_range(0, 99) < 50,
            $urandom_range(0, 99) < 10);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
